turn_signal_seq: RTL and testbench

//  Parametrised tail-light sequencer; next generation of the lab3 Lights block.

---
 rtl/turn_signal_seq_pkg.sv | 21 ++
 rtl/turn_signal_seq_if.sv | 21 ++
 rtl/turn_signal_seq_step_tick.sv | 27 ++
 rtl/turn_signal_seq.sv | 98 +++++++++
 tb/tb_turn_signal_seq.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/turn_signal_seq_pkg.sv
// Shared types and helpers for the turn-signal sequencer.
package tsq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } state_e;

    // Fill pattern: the lowest 'phase' lamps lit, saturating at n lamps.
    function automatic logic [31:0] thermo(input int unsigned phase, input int unsigned n);
        int unsigned p;
        p = (phase > n) ? n : phase;
        if (p >= 32) begin
            return '1;
        end
        return (32'd1 << p) - 32'd1;
    endfunction

endpackage

// File: rtl/turn_signal_seq_if.sv
// Request inputs and lamp outputs of the turn-signal sequencer.
interface turn_signal_seq_if #(
    parameter int unsigned N_LAMPS = 3
);
    logic               L;
    logic               R;
    logic               Brake;
    logic [N_LAMPS-1:0] Lamps_L;
    logic [N_LAMPS-1:0] Lamps_R;
    logic               Busy;

    modport master (
        output L, R, Brake,
        input  Lamps_L, Lamps_R, Busy
    );

    modport slave (
        input  L, R, Brake,
        output Lamps_L, Lamps_R, Busy
    );
endinterface

// File: rtl/turn_signal_seq_step_tick.sv
// Free-running step prescaler; tick is high in the last cycle of each DIV-cycle period.
module step_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic Clk,
    input  logic Rst,
    output logic tick
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/turn_signal_seq.sv
// Tail-light sequencer: thermometer fill per side, hazard flash, brake override.
module turn_signal_seq
    import tsq_pkg::*;
#(
    parameter int unsigned N_LAMPS = 3,
    parameter int unsigned DIV     = 1
) (
    input logic              Clk,
    input logic              Rst,
    turn_signal_seq_if.slave bus
);
    localparam int unsigned      PH_W    = $clog2(N_LAMPS + 1);
    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(N_LAMPS);

    logic tick;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [N_LAMPS-1:0] lamps_l_q, lamps_l_d;
    logic [N_LAMPS-1:0] lamps_r_q, lamps_r_d;
    logic               busy_q, busy_d;
    logic [N_LAMPS-1:0] fill;
    logic [N_LAMPS-1:0] brake_bank;

    step_tick #(.DIV(DIV)) u_step_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;

        // Requests are sampled only at the phase 0 -> 1 boundary; IDLE parks phase at 0.
        if (tick) begin
            if (phase_q == '0) begin
                unique case ({bus.L, bus.R})
                    2'b11:   state_d = HAZARD;
                    2'b10:   state_d = LEFT;
                    2'b01:   state_d = RIGHT;
                    default: state_d = IDLE;
                endcase
                phase_d = (state_d == IDLE) ? '0 : PH_W'(1);
            end else if (phase_q == LAST_PH || state_q == HAZARD) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        fill       = N_LAMPS'(thermo(int'(phase_d), N_LAMPS));
        brake_bank = {N_LAMPS{bus.Brake}};
        lamps_l_d  = '0;
        lamps_r_d  = '0;

        unique case (state_d)
            LEFT: begin
                lamps_l_d = fill;
                lamps_r_d = brake_bank;
            end
            RIGHT: begin
                lamps_l_d = brake_bank;
                lamps_r_d = fill;
            end
            HAZARD: begin
                lamps_l_d = (phase_d != '0) ? '1 : '0;
                lamps_r_d = (phase_d != '0) ? '1 : '0;
            end
            default: begin
                lamps_l_d = brake_bank;
                lamps_r_d = brake_bank;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            lamps_l_q <= '0;
            lamps_r_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            lamps_l_q <= lamps_l_d;
            lamps_r_q <= lamps_r_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.Lamps_L = lamps_l_q;
    assign bus.Lamps_R = lamps_r_q;
    assign bus.Busy    = busy_q;
endmodule

// File: tb/tb_turn_signal_seq.sv
// Scoreboard bench for turn_signal_seq: a DIV=1 and a DIV=4 instance driven by directed vectors.
module tb_turn_signal_seq;

    logic Clk = 1'b0;
    logic Rst;

    turn_signal_seq_if #(.N_LAMPS(3)) bus1 ();
    turn_signal_seq_if #(.N_LAMPS(3)) bus4 ();

    turn_signal_seq #(.N_LAMPS(3), .DIV(1)) dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1.slave)
    );

    turn_signal_seq #(.N_LAMPS(3), .DIV(4)) dut4 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus4.slave)
    );

    always #100 Clk = ~Clk;

    typedef struct {
        string      tag;
        bit         sel4;
        logic [2:0] l;
        logic [2:0] r;
        logic       busy;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_now(input string tag,
                             input logic [2:0] al, input logic [2:0] ar, input logic ab,
                             input logic [2:0] el, input logic [2:0] er, input logic eb);
        n_tests++;
        if ({al, ar, ab} !== {el, er, eb}) begin
            n_fail++;
            $display("FAIL %s: got L=%b R=%b Busy=%b, expected L=%b R=%b Busy=%b",
                     tag, al, ar, ab, el, er, eb);
        end
    endtask

    // Called at a falling edge: drive inputs, queue the response for the next rising edge.
    task automatic vec(input string tag, input bit sel4,
                       input logic l_in, input logic r_in, input logic b_in,
                       input logic [2:0] el, input logic [2:0] er, input logic eb);
        exp_t e;
        if (sel4) begin
            bus4.L = l_in; bus4.R = r_in; bus4.Brake = b_in;
        end else begin
            bus1.L = l_in; bus1.R = r_in; bus1.Brake = b_in;
        end
        e.tag  = tag;
        e.sel4 = sel4;
        e.l    = el;
        e.r    = er;
        e.busy = eb;
        sbq.push_back(e);
        @(negedge Clk);
    endtask

    initial begin
        exp_t m;
        forever begin
            @(posedge Clk);
            #1;
            if (sbq.size() > 0) begin
                m = sbq.pop_front();
                if (m.sel4)
                    check_now(m.tag, bus4.Lamps_L, bus4.Lamps_R, bus4.Busy, m.l, m.r, m.busy);
                else
                    check_now(m.tag, bus1.Lamps_L, bus1.Lamps_R, bus1.Busy, m.l, m.r, m.busy);
            end
        end
    end

    initial begin
        Rst = 1'b1;
        bus1.L = 1'b1; bus1.R = 1'b0; bus1.Brake = 1'b0;
        bus4.L = 1'b0; bus4.R = 1'b0; bus4.Brake = 1'b0;
        #50;
        check_now("reset1", bus1.Lamps_L, bus1.Lamps_R, bus1.Busy, 3'b000, 3'b000, 1'b0);
        check_now("reset4", bus4.Lamps_L, bus4.Lamps_R, bus4.Busy, 3'b000, 3'b000, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;

        // Left fill held for 8 clocks
        vec("left0", 0, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("left1", 0, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("left2", 0, 1, 0, 0, 3'b111, 3'b000, 1);
        vec("left3", 0, 1, 0, 0, 3'b000, 3'b000, 1);
        vec("left4", 0, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("left5", 0, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("left6", 0, 1, 0, 0, 3'b111, 3'b000, 1);
        vec("left7", 0, 1, 0, 0, 3'b000, 3'b000, 1);

        // Drop L at 011: sequence completes, then IDLE at the next boundary
        vec("drop0", 0, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("drop1", 0, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("drop2", 0, 0, 0, 0, 3'b111, 3'b000, 1);
        vec("drop3", 0, 0, 0, 0, 3'b000, 3'b000, 1);
        vec("drop4", 0, 0, 0, 0, 3'b000, 3'b000, 0);
        vec("drop5", 0, 0, 0, 0, 3'b000, 3'b000, 0);

        // Hazard, then R alone only taken at phase 0, then L mid-right ignored
        vec("haz0",  0, 1, 1, 0, 3'b111, 3'b111, 1);
        vec("haz1",  0, 1, 1, 0, 3'b000, 3'b000, 1);
        vec("haz2",  0, 1, 1, 0, 3'b111, 3'b111, 1);
        vec("haz3",  0, 0, 1, 0, 3'b000, 3'b000, 1);
        vec("right0",0, 0, 1, 0, 3'b000, 3'b001, 1);
        vec("right1",0, 1, 0, 0, 3'b000, 3'b011, 1);
        vec("right2",0, 1, 0, 0, 3'b000, 3'b111, 1);
        vec("right3",0, 1, 0, 0, 3'b000, 3'b000, 1);
        vec("swapL", 0, 1, 0, 0, 3'b001, 3'b000, 1);

        // Brake with left turn, then brake alone in IDLE
        vec("brkL0", 0, 1, 0, 1, 3'b011, 3'b111, 1);
        vec("brkL1", 0, 1, 0, 1, 3'b111, 3'b111, 1);
        vec("brkL2", 0, 1, 0, 1, 3'b000, 3'b111, 1);
        vec("brkL3", 0, 1, 0, 1, 3'b001, 3'b111, 1);
        vec("brkL4", 0, 0, 0, 1, 3'b011, 3'b111, 1);
        vec("brkL5", 0, 0, 0, 1, 3'b111, 3'b111, 1);
        vec("brkL6", 0, 0, 0, 1, 3'b000, 3'b111, 1);
        vec("brkI0", 0, 0, 0, 1, 3'b111, 3'b111, 0);
        vec("brkI1", 0, 0, 0, 1, 3'b111, 3'b111, 0);

        // Brake has no effect during hazard
        vec("brkH0", 0, 1, 1, 1, 3'b111, 3'b111, 1);
        vec("brkH1", 0, 1, 1, 1, 3'b000, 3'b000, 1);
        vec("brkH2", 0, 0, 0, 0, 3'b000, 3'b000, 0);

        // Asynchronous reset mid-sequence, restart on R
        vec("preR0", 0, 0, 1, 0, 3'b000, 3'b001, 1);
        vec("preR1", 0, 0, 1, 0, 3'b000, 3'b011, 1);
        #50;
        Rst = 1'b1;
        #1;
        check_now("midrst", bus1.Lamps_L, bus1.Lamps_R, bus1.Busy, 3'b000, 3'b000, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        vec("postR0", 0, 0, 1, 0, 3'b000, 3'b001, 1);
        vec("postR1", 0, 0, 1, 0, 3'b000, 3'b011, 1);
        vec("postR2", 0, 0, 1, 0, 3'b000, 3'b111, 1);
        bus1.R = 1'b0;

        // DIV=4: each step holds 4 clocks, first change on the 4th edge after reset
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        vec("div0",  1, 1, 0, 0, 3'b000, 3'b000, 0);
        vec("div1",  1, 1, 0, 0, 3'b000, 3'b000, 0);
        vec("div2",  1, 1, 0, 0, 3'b000, 3'b000, 0);
        vec("div3",  1, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("div4",  1, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("div5",  1, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("div6",  1, 1, 0, 0, 3'b001, 3'b000, 1);
        vec("div7",  1, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("div8",  1, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("div9",  1, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("div10", 1, 1, 0, 0, 3'b011, 3'b000, 1);
        vec("div11", 1, 1, 0, 0, 3'b111, 3'b000, 1);

        @(negedge Clk);
        @(negedge Clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
